// File: rtl/mig_model.sv
// mig_model: behavioural MIG app_* responder with a write-data FIFO, fixed read latency and refresh back-pressure.
module mig_model #(
  parameter int MEM_AW     = 10,
  parameter int RD_LAT     = 8,
  parameter int WDF_DEPTH  = 4,
  parameter int REF_PERIOD = 512,
  parameter int REF_STALL  = 16
) (
  input  logic         mclk,
  input  logic         mrst,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         err
);
  localparam int PW = $clog2(WDF_DEPTH);
  localparam int RW = $clog2(REF_PERIOD + 2);
  localparam int SW = $clog2(REF_STALL + 2);

  logic [127:0]      r_mem [2**MEM_AW];
  logic [127:0]      r_fd [WDF_DEPTH];
  logic [15:0]       r_fm [WDF_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  logic              r_rdy_en, r_pend, r_stall, r_err;
  logic [MEM_AW-1:0] r_waddr;
  logic [RW-1:0]     r_ref;
  logic [SW-1:0]     r_scnt;
  logic [RD_LAT-1:0] r_vld;
  logic [127:0]      r_rd [RD_LAT];

  logic [MEM_AW-1:0] w_idx, w_widx;
  logic w_full, w_empty, w_acc, w_wcmd, w_rcmd, w_push, w_pop, w_perr;
  logic w_unused;

  assign w_idx       = app_addr[MEM_AW+3:4];
  assign w_unused    = ^{app_addr[27:MEM_AW+4], app_addr[3:0]};
  assign w_full      = r_cnt == (PW+1)'(WDF_DEPTH);
  assign w_empty     = r_cnt == '0;
  assign app_rdy     = r_rdy_en & ~r_stall & ~r_pend;
  assign app_wdf_rdy = r_rdy_en & ~w_full;
  assign w_acc       = app_en & app_rdy;
  assign w_wcmd      = w_acc & (app_cmd == 3'b000);
  assign w_rcmd      = w_acc & (app_cmd == 3'b001);
  assign w_push      = app_wdf_wren & app_wdf_rdy;
  assign w_pop       = ~w_empty & (w_wcmd | r_pend);
  assign w_widx      = r_pend ? r_waddr : w_idx;
  assign w_perr      = (w_acc & (app_cmd[2:1] != 2'b00)) | (app_wdf_wren != app_wdf_end) |
                       (app_wdf_wren & ~app_wdf_rdy);

  assign app_rd_data       = r_rd[RD_LAT-1];
  assign app_rd_data_valid = r_vld[RD_LAT-1];
  assign app_rd_data_end   = r_vld[RD_LAT-1];
  assign err               = r_err;

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      r_rdy_en <= 1'b0;
      r_pend   <= 1'b0;
      r_waddr  <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_vld    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rd[i] <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_err    <= r_err | w_perr;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (w_wcmd & w_empty) begin
        r_pend  <= 1'b1;
        r_waddr <= w_idx;
      end else if (r_pend & ~w_empty) r_pend <= 1'b0;
      r_vld[0] <= w_rcmd;
      r_rd[0]  <= w_rcmd ? r_mem[w_idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
      end
    end
  end

  // Array and FIFO storage are deliberately unreset so memory survives mrst.
  always_ff @(posedge mclk) begin
    if (w_push) begin
      r_fd[r_wp] <= app_wdf_data;
      r_fm[r_wp] <= app_wdf_mask;
    end
    if (w_pop)
      for (int b = 0; b < 16; b++)
        if (!r_fm[r_rp][b]) r_mem[w_widx][8*b +: 8] <= r_fd[r_rp][8*b +: 8];
  end

  // Counter holds during the stall, so one refresh period spans REF_PERIOD + REF_STALL cycles.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      r_ref   <= '0;
      r_stall <= 1'b0;
      r_scnt  <= '0;
    end else if (REF_PERIOD != 0 && REF_STALL != 0) begin
      if (r_stall) begin
        r_scnt <= r_scnt - 1'b1;
        if (r_scnt == SW'(1)) begin
          r_stall <= 1'b0;
          r_ref   <= '0;
        end
      end else if (r_ref == RW'(REF_PERIOD - 1)) begin
        r_stall <= 1'b1;
        r_scnt  <= SW'(REF_STALL);
      end else r_ref <= r_ref + 1'b1;
    end
  end
endmodule
